// File: rtl/audio_pkg.sv
// Shared audio types and default framing constants.
// Used by the I2S receive and transmit paths.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 16;
  localparam int AUDIO_SLOT_WIDTH   = 32;
  localparam int AUDIO_FRAME_BITS   = 2 * AUDIO_SLOT_WIDTH;

  typedef struct packed {
    logic [AUDIO_SAMPLE_WIDTH-1:0] l;
    logic [AUDIO_SAMPLE_WIDTH-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// MCLK/BCK dividers, BCK fall strobe and bit counter/LRCK.
// Strobes are combinational and line up with the BCK 1->0 toggle.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int SLOT_WIDTH    = AUDIO_SLOT_WIDTH,
  parameter int BCK_HALF_DIV  = 12,
  parameter int MCLK_HALF_DIV = 3,
  localparam int BW = $clog2(2 * SLOT_WIDTH)
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  output logic          i2s_mclk,
  output logic          i2s_bck,
  output logic          i2s_lrck,
  output logic          fall,
  output logic          load,
  output logic [BW-1:0] slot_k,
  output logic          slot_r
);

  localparam int MW = $clog2(MCLK_HALF_DIV + 1);
  localparam int KW = $clog2(BCK_HALF_DIV + 1);
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SLOT = BW'(SLOT_WIDTH);

  logic [MW-1:0] mclk_cnt;
  logic [KW-1:0] bck_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          mclk_tc;
  logic          bck_tc;

  assign mclk_tc = mclk_cnt == MW'(MCLK_HALF_DIV - 1);
  assign bck_tc  = bck_cnt == KW'(BCK_HALF_DIV - 1);
  assign fall    = bck_tc && i2s_bck;
  assign load    = fall && (bit_cnt == LAST);

  // Next bit position and its slot split.
  always_comb begin
    bit_nxt = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    slot_r  = bit_nxt >= SLOT;
    slot_k  = slot_r ? bit_nxt - SLOT : bit_nxt;
  end

  // MCLK divider.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      mclk_cnt <= '0;
      i2s_mclk <= 1'b0;
    end else begin
      mclk_cnt <= mclk_tc ? '0 : mclk_cnt + 1'b1;
      if (mclk_tc)
        i2s_mclk <= ~i2s_mclk;
    end
  end

  // BCK divider.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      bck_cnt <= '0;
      i2s_bck <= 1'b0;
    end else begin
      bck_cnt <= bck_tc ? '0 : bck_cnt + 1'b1;
      if (bck_tc)
        i2s_bck <= ~i2s_bck;
    end
  end

  // Bit counter and word select advance on BCK fall.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      bit_cnt  <= LAST;
      i2s_lrck <= 1'b0;
    end else if (fall) begin
      bit_cnt  <= bit_nxt;
      i2s_lrck <= slot_r;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter with one-frame holding register.
// Option: I2S_TX_UNDERRUN_MUTE_EN sends zeros on underrun.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH    = AUDIO_SLOT_WIDTH,
  parameter int BCK_HALF_DIV  = 12,
  parameter int MCLK_HALF_DIV = 3
) (
  input  logic                    clk_pixel,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    i2s_mclk,
  output logic                    i2s_bck,
  output logic                    i2s_lrck,
  output logic                    i2s_dout,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int MSB = SAMPLE_WIDTH - 1;

  logic                    fall;
  logic                    load;
  logic [BW-1:0]           slot_k;
  logic                    slot_r;
  logic                    in_data;
  logic                    accept;
  logic                    hold_full;
  stereo_sample_t          hold;
  stereo_sample_t          last;
  stereo_sample_t          src;
  logic [SAMPLE_WIDTH-1:0] sr_l;
  logic [SAMPLE_WIDTH-1:0] sr_r;

  i2s_clk_gen #(
    .SLOT_WIDTH   (SLOT_WIDTH),
    .BCK_HALF_DIV (BCK_HALF_DIV),
    .MCLK_HALF_DIV(MCLK_HALF_DIV)
  ) u_clk_gen (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .i2s_mclk (i2s_mclk),
    .i2s_bck  (i2s_bck),
    .i2s_lrck (i2s_lrck),
    .fall     (fall),
    .load     (load),
    .slot_k   (slot_k),
    .slot_r   (slot_r)
  );

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  assign in_data      = (slot_k != '0) &&
                        (slot_k <= BW'(SAMPLE_WIDTH));

  // Frame source: fresh pair, else underrun fallback.
  always_comb begin
    src = '0;
    if (hold_full)
      src = hold;
    else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      src = '0;
`else
      src = last;
`endif
    end
  end

  // Holding register and handshake; no bypass into a load.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold.l    <= sample_l;
      hold.r    <= sample_r;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Frame load, shift-out and status pulses.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      sr_l        <= '0;
      sr_r        <= '0;
      last        <= '0;
      i2s_dout    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && !hold_full;
      if (load) begin
        sr_l     <= src.l;
        sr_r     <= src.r;
        i2s_dout <= 1'b0;
        if (hold_full)
          last <= hold;
      end else if (fall) begin
        if (!in_data)
          i2s_dout <= 1'b0;
        else if (slot_r) begin
          i2s_dout <= sr_r[MSB];
          sr_r     <= {sr_r[MSB-1:0], 1'b0};
        end else begin
          i2s_dout <= sr_l[MSB];
          sr_l     <= {sr_l[MSB-1:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx against a timeline model.
// Outputs are derived from the cycle index since reset release.
module tb_i2s_tx;

  localparam int SW    = 16;
  localparam int BH    = 12;
  localparam int MH    = 3;
  localparam int FCYC  = 4 * 32 * BH;
  localparam int LOAD0 = 2 * BH;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_mclk;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_dout;
  logic        frame_start;
  logic        underrun;

  always #5 clk_pixel = ~clk_pixel;

  i2s_tx dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_mclk    (i2s_mclk),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_dout    (i2s_dout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int          t;
  int          n_chk;
  int          n_err;
  int          nloads;
  int          mode;
  int          ur_cnt;
  bit          m_full, m_fs, m_ur, m_acc;
  logic [15:0] h_l, h_r, l_l, l_r, c_l, c_r;
  logic [15:0] cap_l, cap_r;
  logic [15:0] got_l[$];
  logic [15:0] got_r[$];

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h",
               name, t, got, exp);
    end
  endtask

  function automatic logic exp_lrck();
    int f;
    f = t / LOAD0;
    if (f < 1) return 1'b0;
    return ((f - 1) % 64) >= 32;
  endfunction

  function automatic logic exp_dout();
    int f, bc, k;
    f = t / LOAD0;
    if (f < 1) return 1'b0;
    bc = (f - 1) % 64;
    k  = bc % 32;
    if (k < 1 || k > SW) return 1'b0;
    return (bc >= 32) ? c_r[SW-k] : c_l[SW-k];
  endfunction

  task automatic cycle();
    bit ld;
    int bc, k;
    @(posedge clk_pixel);
    if (!rst_n) begin
      t = 0; m_full = 0; m_fs = 0; m_ur = 0; m_acc = 0;
      h_l = 0; h_r = 0; l_l = 0; l_r = 0; c_l = 0; c_r = 0;
      cap_l = 0; cap_r = 0; nloads = 0;
      got_l.delete(); got_r.delete();
    end else begin
      t++;
      ld    = (t >= LOAD0) && ((t - LOAD0) % FCYC == 0);
      m_fs  = ld;
      m_ur  = ld && !m_full;
      m_acc = sample_valid && !m_full;
      if (ld) begin
        if (m_full) begin
          c_l = h_l; c_r = h_r; l_l = h_l; l_r = h_r;
        end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
          c_l = 0; c_r = 0;
`else
          c_l = l_l; c_r = l_r;
`endif
        end
      end
      if (m_acc) begin
        h_l = sample_l; h_r = sample_r; m_full = 1;
      end else if (ld) m_full = 0;
    end
    #1;
    chk("mclk", i2s_mclk, (t / MH) % 2);
    chk("bck", i2s_bck, (t / BH) % 2);
    chk("lrck", i2s_lrck, exp_lrck());
    chk("dout", i2s_dout, exp_dout());
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_ur);
    chk("ready", sample_ready, !m_full);
    if (underrun === 1'b1) ur_cnt++;
    if (rst_n && t >= LOAD0 && t % LOAD0 == 0) begin
      if (m_fs) begin
        if (nloads > 0) begin
          got_l.push_back(cap_l); got_r.push_back(cap_r);
        end
        cap_l = 0; cap_r = 0; nloads++;
      end else begin
        bc = (t / LOAD0 - 1) % 64;
        k  = bc % 32;
        if (k >= 1 && k <= SW) begin
          if (bc >= 32) cap_r = {cap_r[14:0], i2s_dout};
          else cap_l = {cap_l[14:0], i2s_dout};
        end
      end
    end
    case (mode)
      1: begin
        sample_valid = 1'b1;
        if (m_acc) begin
          sample_l = 16'($urandom); sample_r = 16'($urandom);
        end
      end
      2: begin
        if (m_acc) sample_valid = 1'b0;
        if (!sample_valid && $urandom_range(0, 1999) == 0) begin
          sample_valid = 1'b1;
          sample_l = 16'($urandom); sample_r = 16'($urandom);
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (t < target && guard < 40000) begin
      cycle(); guard++;
    end
  endtask

  task automatic do_reset();
    mode = 0;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    ur_cnt = 0;
  endtask

  task automatic chk_frame(string name, int idx,
                           logic [15:0] el, logic [15:0] er);
    if (got_l.size() <= idx) begin
      chk({name, "_missing"}, got_l.size(), idx + 1);
    end else begin
      chk({name, "_l"}, got_l[idx], el);
      chk({name, "_r"}, got_r[idx], er);
    end
  endtask

  initial begin
    int fa, guard;
    logic [15:0] el, er;
    n_chk = 0; n_err = 0; mode = 0; ur_cnt = 0;

    do_reset();
    chk("rst_bck", i2s_bck, 0);
    chk("rst_dout", i2s_dout, 0);
    chk("rst_ready", sample_ready, 1);
    run_to(11);
    chk("bck_pre_rise", i2s_bck, 0);
    cycle();
    chk("bck_rise12", i2s_bck, 1);
    run_to(23);
    chk("fs_pre24", frame_start, 0);
    cycle();
    chk("bck_fall24", i2s_bck, 0);
    chk("fs_24", frame_start, 1);
    chk("ur_24", underrun, 1);
    run_to(LOAD0 + FCYC);
    chk_frame("idle_frame", 0, 16'h0000, 16'h0000);

    do_reset();
    sample_valid = 1'b1;
    sample_l = 16'hA5C3; sample_r = 16'h8001;
    cycle();
    sample_valid = 1'b0;
    chk("ready_after_acc", sample_ready, 0);
    run_to(791);
    chk("lrck_pre", i2s_lrck, 0);
    cycle();
    chk("lrck_rise", i2s_lrck, 1);
    run_to(LOAD0 + FCYC - 1);
    chk("no_underrun_b", ur_cnt, 0);
    cycle();
    chk_frame("a5c3", 0, 16'hA5C3, 16'h8001);

    do_reset();
    sample_l = 16'($urandom); sample_r = 16'($urandom);
    mode = 1;
    run_to(LOAD0 + 10 * FCYC);
    chk("stream_underruns", ur_cnt, 0);
    chk("stream_frames", nloads, 11);

    mode = 0;
    sample_valid = 1'b0;
    guard = 0;
    while (m_full && guard < 2 * FCYC) begin
      cycle(); guard++;
    end
    chk("wait_ready_timeout", guard < 2 * FCYC, 1);
    sample_valid = 1'b1;
    sample_l = 16'h1234; sample_r = 16'h4321;
    cycle();
    fa = nloads;
    sample_valid = 1'b0;
    repeat (3 * FCYC) cycle();
    chk_frame("last_pair", fa, 16'h1234, 16'h4321);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    chk_frame("underrun_frame", fa + 1, 16'h0000, 16'h0000);
`else
    chk_frame("underrun_frame", fa + 1, 16'h1234, 16'h4321);
`endif

    do_reset();
    run_to(23);
    el = 16'($urandom); er = 16'($urandom);
    sample_valid = 1'b1;
    sample_l = el; sample_r = er;
    cycle();
    sample_valid = 1'b0;
    chk("same_cycle_ur", underrun, 1);
    run_to(LOAD0 + 2 * FCYC);
    chk_frame("same_cycle_f0", 0, 16'h0000, 16'h0000);
    chk_frame("same_cycle_f1", 1, el, er);

    do_reset();
    sample_valid = 1'b1;
    sample_l = 16'h0F0F; sample_r = 16'hF0F0;
    cycle();
    sample_l = 16'h5555; sample_r = 16'hAAAA;
    run_to(25);
    sample_valid = 1'b0;
    chk("hold_full_mid", sample_ready, 0);
    run_to(41 * LOAD0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_bck", i2s_bck, 0);
    chk("mid_rst_lrck", i2s_lrck, 0);
    chk("mid_rst_dout", i2s_dout, 0);
    chk("mid_rst_mclk", i2s_mclk, 0);
    chk("mid_rst_ready", sample_ready, 1);
    run_to(23);
    chk("mid_rst_fs23", frame_start, 0);
    cycle();
    chk("mid_rst_fs24", frame_start, 1);
    chk("mid_rst_ur24", underrun, 1);

    do_reset();
    mode = 2;
    run_to(LOAD0 + 4 * FCYC);
    mode = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Master-mode I2S transmitter that drives a PCM DAC for audio pass-through. Runs on `clk_pixel` and generates MCLK, BCK and LRCK from internal clock-enable dividers. Accepts stereo 16-bit samples through a valid/ready handshake with a one-frame holding register, then serializes them in standard I2S format with a 32-bit slot per channel. Sits beside the I2S receive path: the receiver's `sample_l`/`sample_r` (or a processed copy) feed this block.

## Interface
- `SAMPLE_WIDTH`, default 16: bits per channel sample.
- `SLOT_WIDTH`, default 32: BCK periods per channel slot. Must be ≥ SAMPLE_WIDTH+1.
- `BCK_HALF_DIV`, default 12: `clk_pixel` cycles per BCK half-period. At 73.8 MHz this gives 3.075 MHz BCK and 48.05 kHz Fs.
- `MCLK_HALF_DIV`, default 3: `clk_pixel` cycles per MCLK half-period. At 73.8 MHz this gives 12.3 MHz.

Ports:
- `clk_pixel`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_l`  in  SAMPLE_WIDTH  left sample, two's complement.
- `sample_r`  in  SAMPLE_WIDTH  right sample.
- `sample_valid`  in  1  sample pair presented.
- `sample_ready`  out  1  holding register empty; equals !hold_full.
- `i2s_mclk`  out  1  master clock.
- `i2s_bck`  out  1  bit clock.
- `i2s_lrck`  out  1  word select; 0 = left, 1 = right.
- `i2s_dout`  out  1  serial data.
- `frame_start`  out  1  one-cycle pulse on every frame load.
- `underrun`  out  1  one-cycle pulse when a frame load finds the holding register empty.

## Operation
- **Dividers.** The MCLK counter runs 0..MCLK_HALF_DIV-1 and toggles `i2s_mclk` at its terminal count. The BCK counter runs 0..BCK_HALF_DIV-1 and toggles `i2s_bck` at its terminal count. Both counters reset to 0.
- **BCK fall event.** Occurs in the cycle where `i2s_bck` is toggled 1→0. All data and LRCK state advances only on this event.
- **Bit counter.** `bit_cnt` spans 0..2·SLOT_WIDTH-1 and increments on each fall event, wrapping to 0. `i2s_lrck` = bit_cnt ≥ SLOT_WIDTH.
- **Slot bit position.** k = bit_cnt mod SLOT_WIDTH.
  - k = 0: `i2s_dout` = 0.
  - k = 1..SAMPLE_WIDTH: sample bits, MSB first. This gives the I2S one-BCK delay after the LRCK edge.
  - k > SAMPLE_WIDTH: `i2s_dout` = 0.
- **Frame load.** Happens on the fall event where bit_cnt wraps to 0. `frame_start` pulses.
  - hold_full: the holding register is copied into the left/right shift registers and the last-frame copy, and hold_full is cleared.
  - Holding register empty: `underrun` pulses and the fallback data is loaded (see Configuration).
- **Handshake.** Accept occurs when `sample_valid` && `sample_ready`; hold_full is set the next cycle. Inputs are captured only on accept.
- **Accept and frame load in the same cycle while empty.** The frame load sees the register as empty: `underrun` pulses and the fallback data is loaded. The accepted pair goes into the holding register for the next frame. No bypass path.
- **Reset.** Clears counters, hold_full, shift registers and the last-frame copy. bit_cnt resets to 2·SLOT_WIDTH-1, so the first fall event is a frame load.

## Timing
- **Reset values.**
  - 0: `i2s_mclk`, `i2s_bck`, `i2s_lrck`, `i2s_dout`, `frame_start`, `underrun`.
  - 1: `sample_ready`, from the first cycle after reset release.
- **Output registers.** All I2S outputs are registered. `i2s_dout` and `i2s_lrck` change in the same cycle as the BCK falling edge, giving the DAC half a BCK period of setup and hold.
- **Edge times after reset release.** The first BCK rise is at cycle BCK_HALF_DIV and the first fall/frame load is at cycle 2·BCK_HALF_DIV.
- **Periods.** The frame period is 4·SLOT_WIDTH·BCK_HALF_DIV cycles (1536 with defaults).
- **Ready latency.** `sample_ready` falls the cycle after an accept and rises the cycle after a frame load.
- **Reset mid-frame.** Any cycle with `rst_n` low restores every reset value on the next edge. A partial frame is abandoned.

## Configuration
- `I2S_TX_UNDERRUN_MUTE_EN`
  - Defined: an underrun frame loads zeros for both channels.
  - Undefined: an underrun frame reloads the last-frame copy, repeating the previous sample pair.
- The `underrun` pulse is identical in both builds.

## Structure
- **Shared package `audio_pkg`.** Holds the `stereo_sample_t` struct (l, r of SAMPLE_WIDTH) and the default `SLOT_WIDTH`/`FRAME_BITS` localparams; the receive path uses them too.
- **Sub-module `i2s_clk_gen`.** Contains the MCLK and BCK dividers, the fall-event strobe and bit_cnt/LRCK. `i2s_tx` contains the holding register, shift registers and handshake.

## Test plan
- Reset release with `sample_valid` = 0 → `i2s_bck` rises at cycle 12 and falls at cycle 24; `frame_start` and `underrun` pulse at cycle 24; `i2s_dout` stays 0 for the whole frame.
- Accept L = 16'hA5C3, R = 16'h8001 before the first load → left k = 1..16 reads 1010010111000011; `i2s_lrck` rises on the fall event where bit_cnt = 32; right reads 1000000000000001 at k = 1..16; no underrun.
- `sample_valid` held high with a new pair each accept → `sample_ready` drops for exactly one frame period between accepts; no `underrun` over 10 frames; every pair appears in order.
- Stop supplying after pair 16'h1234/16'h4321 → next frame: `underrun` pulses; dout repeats 1234/4321, or all zeros with `I2S_TX_UNDERRUN_MUTE_EN`.
- Accept with hold empty in the frame-load cycle → `underrun` pulses; the pair appears in the following frame.
- `rst_n` low for one cycle at bit_cnt = 40 with hold_full set → all outputs 0; `sample_ready` = 1 next cycle; first new load occurs 24 cycles later.
